// File: rtl/slow_tick_pkg.sv
// Shared types and default parameters for the slow-clock receiver.
package slow_tick_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        MEASURE = 2'd1,
        STALLED = 2'd2
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 29;
    localparam int DEF_TIMEOUT     = 268435456;

endpackage

// File: rtl/slow_tick_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level (slow clock, buttons).
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/slow_tick_sync.sv
// Samples a divided slow clock in the fast domain, emits rise/fall enables,
// measures the rise-to-rise period and flags a stall when rises stop.
module slow_tick_sync
    import slow_tick_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             slow_clk,
    input  logic             clr,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [7:0]       tick_count,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             stalled,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic             s;
    logic             s_d;
    logic             rise_det;
    logic             fall_det;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_nxt;
    logic [7:0]       tick_count_nxt;
    logic [CNT_W-1:0] period_nxt;
    logic             period_vld_nxt;
    logic             stalled_nxt;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk_in),
        .rst_n (rst_n),
        .d     (slow_clk),
        .q     (s)
    );

    assign rise_det = s & ~s_d;
    assign fall_det = ~s & s_d;

    // Edge pulses are never gated by clr so downstream enables stay regular.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s_d       <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else begin
            s_d       <= s;
            tick_rise <= rise_det;
            tick_fall <= fall_det;
        end
    end

    // Saturating increment doubles as the period value (cnt + 1).
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        cnt_nxt        = cnt_inc;
        tick_count_nxt = tick_count;
        if (clr) begin
            cnt_nxt        = '0;
            tick_count_nxt = '0;
        end else if (rise_det) begin
            cnt_nxt        = '0;
            tick_count_nxt = tick_count + 8'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACQUIRE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ACQUIRE;
        end else begin
            case (state)
                ACQUIRE: if (rise_det) state_nxt = MEASURE;
                MEASURE: if (!rise_det && cnt == TO_LAST) state_nxt = STALLED;
                STALLED: if (rise_det) state_nxt = MEASURE;
                default: state_nxt = ACQUIRE;
            endcase
        end
    end

    // A rise on the timeout cycle wins; the gap ending a stall is not a period.
    always_comb begin
        period_nxt     = period;
        period_vld_nxt = period_vld;
        stalled_nxt    = stalled;
        if (clr) begin
            period_nxt     = '0;
            period_vld_nxt = 1'b0;
            stalled_nxt    = 1'b0;
        end else begin
            case (state)
                MEASURE: begin
                    if (rise_det) begin
                        period_nxt     = cnt_inc;
                        period_vld_nxt = 1'b1;
                    end else if (cnt == TO_LAST) begin
                        stalled_nxt    = 1'b1;
                        period_vld_nxt = 1'b0;
                    end
                end
                STALLED: if (rise_det) stalled_nxt = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            tick_count <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            tick_count <= tick_count_nxt;
            period     <= period_nxt;
            period_vld <= period_vld_nxt;
            stalled    <= stalled_nxt;
        end
    end

    assign state_dbg = state;

endmodule
